// File: rtl/cpu_trace_buffer.sv
// cpu_trace_buffer
//   Captures one trace entry per retired instruction from cpu_top and
//   queues it in a show-ahead FIFO for a host/debug consumer. An entry is
//   recorded only when the PC changes, so a stalled PC is not re-recorded.
//   A PC that repeats HALT_CYCLES times in a row counts as a halt (the
//   program has ended in a self-loop), and capture stops.
//
//   Optional build macro: TRACE_MEM_DATA_EN
//     When defined, each entry also stores mem_data, and the extra port
//     out_mem presents it. When undefined, entries hold only {pc, ans}
//     and mem_data is ignored.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   start      single-cycle pulse: begin capture (IDLE) or resume (HALTED)
//   pc_value   PC from cpu_top
//   ans        ALU/writeback result from cpu_top
//   mem_data   data-memory read value (used only with TRACE_MEM_DATA_EN)
//   out_valid  head entry available
//   out_ready  consumer accepts the head entry
//   out_pc     head entry PC (0 when empty)
//   out_ans    head entry result (0 when empty)
//   out_mem    head entry mem_data (TRACE_MEM_DATA_EN only, 0 when empty)
//   level      FIFO occupancy, 0..DEPTH
//   dropped    samples lost to a full FIFO, saturating at 16'hFFFF
//   halted     high in HALTED state
//   busy       high in CAPTURE state
//
// Output handshake: the head entry is transferred on every clock edge
// where out_valid && out_ready are both high. out_valid never depends on
// out_ready, and the head entry is stable while out_valid is high and
// out_ready is low.
//
// FSM state is visible on busy (CAPTURE) and halted (HALTED); both low
// means IDLE.

module cpu_trace_buffer #(
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = 4,
  parameter int HALT_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       pc_value,
  input  logic [31:0]       ans,
  input  logic [31:0]       mem_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_pc,
  output logic [31:0]       out_ans,
`ifdef TRACE_MEM_DATA_EN
  output logic [31:0]       out_mem,
`endif
  output logic [ADDR_W:0]   level,
  output logic [15:0]       dropped,
  output logic              halted,
  output logic              busy
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CAPTURE = 2'd1;
  localparam logic [1:0] HALTED  = 2'd2;

`ifdef TRACE_MEM_DATA_EN
  localparam int EW = 96;
`else
  localparam int EW = 64;
`endif

  // Wide enough to hold the value HALT_CYCLES itself.
  localparam int RW = (HALT_CYCLES < 2) ? 1 : $clog2(HALT_CYCLES + 1);

  localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W + 1)'(DEPTH);

  logic [1:0]        state, next_state;
  logic [31:0]       last_pc;
  logic              first;
  logic [RW-1:0]     rep_cnt;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [EW-1:0]     fifo_mem [DEPTH];
  logic [EW-1:0]     entry_in, head;

  logic sample, new_pc, push_req, pop, full, push_ok, drop, hit_halt, resume;

`ifdef TRACE_MEM_DATA_EN
  assign entry_in = {pc_value, ans, mem_data};
`else
  assign entry_in = {pc_value, ans};
  logic unused_mem_data;
  assign unused_mem_data = ^mem_data;
`endif

  assign sample   = (state == CAPTURE);
  assign new_pc   = first || (pc_value != last_pc);
  assign push_req = sample && new_pc;
  assign full     = (level == FULL_LEVEL);
  assign pop      = out_valid && out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_ok  = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;
  assign hit_halt = sample && !new_pc && (rep_cnt == RW'(HALT_CYCLES - 1));
  assign resume   = (state == HALTED) && start;

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = CAPTURE;
      CAPTURE: if (hit_halt) next_state = HALTED;
      HALTED:  if (start) next_state = CAPTURE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      halted  <= 1'b0;
      last_pc <= '0;
      first   <= 1'b1;
      rep_cnt <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      dropped <= '0;
    end else begin
      state  <= next_state;
      busy   <= (next_state == CAPTURE);
      halted <= (next_state == HALTED);

      if (resume) begin
        first   <= 1'b1;
        rep_cnt <= '0;
      end else if (push_req) begin
        first   <= 1'b0;
        last_pc <= pc_value;
        rep_cnt <= '0;
      end else if (sample) begin
        rep_cnt <= rep_cnt + RW'(1);
      end

      if (push_ok) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + ADDR_W'(1);

      case ({push_ok, pop})
        2'b10:   level <= level + (ADDR_W + 1)'(1);
        2'b01:   level <= level - (ADDR_W + 1)'(1);
        default: level <= level;
      endcase

      if (resume)
        dropped <= '0;
      else if (drop && (dropped != 16'hFFFF))
        dropped <= dropped + 16'd1;
    end
  end

  // Storage needs no reset: entries are only visible through level.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= entry_in;
  end

  assign out_valid = (level != '0);
  assign head      = fifo_mem[rd_ptr];
  assign out_pc    = out_valid ? head[EW-1 -: 32] : 32'd0;
  assign out_ans   = out_valid ? head[EW-33 -: 32] : 32'd0;
`ifdef TRACE_MEM_DATA_EN
  assign out_mem   = out_valid ? head[31:0] : 32'd0;
`endif

endmodule

// File: tb/tb_cpu_trace_buffer.sv
module tb_cpu_trace_buffer;

  localparam int DEPTH = 16;
  localparam int HALT  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] pc_value, ans, mem_data;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_ans;
  logic [31:0] out_mem_w;
  logic [4:0]  level;
  logic [15:0] dropped;
  logic        halted, busy;

  int checks = 0;
  int errors = 0;

  cpu_trace_buffer #(.DEPTH(DEPTH), .ADDR_W(4), .HALT_CYCLES(HALT)) dut (
    .clk(clk), .rst(rst), .start(start),
    .pc_value(pc_value), .ans(ans), .mem_data(mem_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_ans(out_ans),
`ifdef TRACE_MEM_DATA_EN
    .out_mem(out_mem_w),
`endif
    .level(level), .dropped(dropped), .halted(halted), .busy(busy)
  );

`ifndef TRACE_MEM_DATA_EN
  assign out_mem_w = 32'd0;
`endif

  // clock / reset
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // mode: 0 idle, 1 capturing, 2 halted
  logic [95:0] mq[$];
  int          m_mode  = 0;
  int          m_drop  = 0;
  bit          m_first = 1'b1;
  logic [31:0] m_last  = '0;
  int          m_rep   = 0;

  task automatic model_step();
    int  pre;
    bit  do_pop, do_push;
    if (rst !== 1'b1) begin
      mq.delete();
      m_mode = 0; m_drop = 0; m_first = 1'b1; m_last = '0; m_rep = 0;
      return;
    end
    pre     = mq.size();
    do_pop  = (pre != 0) && out_ready;
    do_push = 1'b0;
    case (m_mode)
      0: if (start) m_mode = 1;
      1: begin
        if (m_first || pc_value != m_last) begin
          do_push = 1'b1; m_first = 1'b0; m_last = pc_value; m_rep = 0;
        end else begin
          m_rep++;
          if (m_rep == HALT) m_mode = 2;
        end
      end
      default: if (start) begin
        m_mode = 1; m_rep = 0; m_drop = 0; m_first = 1'b1;
      end
    endcase
    if (do_pop) void'(mq.pop_front());
    if (do_push) begin
      if (pre == DEPTH && !do_pop) begin
        if (m_drop != 16'hFFFF) m_drop++;
      end else begin
`ifdef TRACE_MEM_DATA_EN
        mq.push_back({pc_value, ans, mem_data});
`else
        mq.push_back({pc_value, ans, 32'd0});
`endif
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst);
    model_step();
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_outputs();
    logic [95:0] h;
    h = (mq.size() != 0) ? mq[0] : 96'd0;
    chk("out_valid", {31'd0, out_valid}, {31'd0, mq.size() != 0});
    chk("out_pc",    out_pc,  h[95:64]);
    chk("out_ans",   out_ans, h[63:32]);
`ifdef TRACE_MEM_DATA_EN
    chk("out_mem",   out_mem_w, h[31:0]);
`endif
    chk("level",     {27'd0, level}, 32'(mq.size()));
    chk("dropped",   {16'd0, dropped}, 32'(m_drop));
    chk("halted",    {31'd0, halted}, {31'd0, m_mode == 2});
    chk("busy",      {31'd0, busy},   {31'd0, m_mode == 1});
  endtask

  initial forever begin
    @(negedge clk);
    if (rst === 1'b1) compare_outputs();
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b0; start = 1'b0; out_ready = 1'b0;
    cyc(); cyc();
    rst = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0; start = 1'b0; out_ready = 1'b0;
    pc_value = '0; ans = '0; mem_data = '0;

    // reset state
    do_reset();
    chk("rst_level",  {27'd0, level}, 32'd0);
    chk("rst_valid",  {31'd0, out_valid}, 32'd0);
    chk("rst_pc",     out_pc, 32'd0);
    chk("rst_busy",   {31'd0, busy}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_drop",   {16'd0, dropped}, 32'd0);

    // streaming with consumer always ready
    pulse_start();
    chk("t1_busy", {31'd0, busy}, 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pc_value = 32'(i * 4); ans = $urandom; mem_data = $urandom;
      cyc();
      chk("t1_valid", {31'd0, out_valid}, 32'd1);
      chk("t1_pc",    out_pc, 32'(i * 4));
      chk("t1_ans",   out_ans, ans);
`ifdef TRACE_MEM_DATA_EN
      chk("t1_mem",   out_mem_w, mem_data);
`endif
      chk("t1_level", {27'd0, level}, 32'd1);
    end
    cyc();
    chk("t1_empty", {27'd0, level}, 32'd0);
    chk("t1_drop",  {16'd0, dropped}, 32'd0);

    // overflow then drain
    do_reset();
    pulse_start();
    for (int i = 0; i < 20; i++) begin
      pc_value = 32'(i * 4); ans = $urandom; mem_data = $urandom;
      cyc();
    end
    chk("t2_level", {27'd0, level}, 32'd16);
    chk("t2_drop",  {16'd0, dropped}, 32'd4);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("t2_drain_pc", out_pc, 32'(i * 4));
      cyc();
    end
    chk("t2_level0", {27'd0, level}, 32'd0);
    chk("t2_halted", {31'd0, halted}, 32'd1);

    // halt detection and resume
    do_reset();
    pulse_start();
    pc_value = 32'h1C; cyc();
    pc_value = 32'h20; cyc();
    for (int i = 0; i < HALT; i++) begin
      chk("t3_busy_pre", {31'd0, busy}, 32'd1);
      cyc();
    end
    chk("t3_halted", {31'd0, halted}, 32'd1);
    chk("t3_busy",   {31'd0, busy}, 32'd0);
    chk("t3_level",  {27'd0, level}, 32'd2);
    pc_value = 32'h24; cyc(); cyc();
    chk("t3_nopush", {27'd0, level}, 32'd2);
    pulse_start();
    chk("t3_startcyc", {27'd0, level}, 32'd2);
    cyc();
    chk("t3_resume", {27'd0, level}, 32'd3);
    chk("t3_busy2",  {31'd0, busy}, 32'd1);

    // full FIFO with simultaneous push and pop
    do_reset();
    pulse_start();
    for (int i = 0; i < 16; i++) begin
      pc_value = 32'h100 + 32'(i * 4); ans = $urandom; cyc();
    end
    chk("t4_full", {27'd0, level}, 32'd16);
    pc_value = 32'h200; out_ready = 1'b1; cyc();
    chk("t4_level", {27'd0, level}, 32'd16);
    chk("t4_drop",  {16'd0, dropped}, 32'd0);
    for (int i = 0; i < 15; i++) cyc();
    chk("t4_last", out_pc, 32'h200);

    // asynchronous reset mid-cycle
    do_reset();
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      pc_value = 32'h300 + 32'(i * 4); cyc();
    end
    chk("t5_level5", {27'd0, level}, 32'd5);
    #1 rst = 1'b0;
    #1;
    chk("t5_level",  {27'd0, level}, 32'd0);
    chk("t5_valid",  {31'd0, out_valid}, 32'd0);
    chk("t5_busy",   {31'd0, busy}, 32'd0);
    chk("t5_halted", {31'd0, halted}, 32'd0);
    cyc();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pc_value = 32'h400 + 32'(i * 4); cyc();
    end
    chk("t5_ignored", {27'd0, level}, 32'd0);
    chk("t5_idle",    {31'd0, busy}, 32'd0);

    // randomized traffic against the model
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      start = ($urandom_range(0, 19) == 0);
      if ((n / 150) % 2 == 1) out_ready = ($urandom_range(0, 7) == 0);
      else                    out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) >= 5) pc_value = 32'($urandom_range(0, 15) * 4);
      ans = $urandom; mem_data = $urandom;
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_trace_buffer.md
Name: cpu_trace_buffer

Overview:
- Sits directly downstream of cpu_top and consumes its pc_value, ans and mem_data debug outputs.
- Records one trace entry per retired instruction (deduplicated on PC) into a show-ahead FIFO.
- Drains entries to a host/debug consumer over a valid/ready stream.
- Detects a CPU halt, meaning the PC is stuck (self-loop end-of-program), and stops capture.

Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- ADDR_W, 4, log2(DEPTH).
- HALT_CYCLES, 4, consecutive repeated-PC samples that declare a halt; minimum 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset (0 = reset asserted).
- start  input  1  single-cycle pulse: begin/resume capture.
- pc_value  input  32  PC from cpu_top.
- ans  input  32  ALU/writeback result from cpu_top.
- mem_data  input  32  data-memory read value from cpu_top; used only with the optional feature.
- out_valid  output  1  head entry available.
- out_ready  input  1  consumer accepts the head entry.
- out_pc  output  32  head entry PC.
- out_ans  output  32  head entry result.
- level  output  ADDR_W+1  current FIFO occupancy, 0..DEPTH.
- dropped  output  16  samples lost to a full FIFO; saturates at 16'hFFFF.
- halted  output  1  high in HALTED state.
- busy  output  1  high in CAPTURE state.

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous, active-low.
- Reset (rst=0, any time including mid-capture):
  - state = IDLE; FIFO emptied, level = 0; contents discarded.
  - out_valid = 0, out_pc = 0, out_ans = 0, dropped = 0, halted = 0, busy = 0.
  - last_pc cleared; first-sample flag set; repeat counter = 0.
- State IDLE:
  - No sampling.
  - start=1 -> CAPTURE on next edge; the start cycle itself is not sampled.
- State CAPTURE (one sample per clock):
  - First sample after entering CAPTURE, or pc_value != last_pc:
    - push {pc_value, ans}; last_pc <= pc_value; repeat counter <= 0.
  - pc_value == last_pc:
    - no push; repeat counter increments.
    - When the increment makes the counter reach HALT_CYCLES: next state HALTED.
  - A push while level==DEPTH with no pop in the same cycle is discarded; dropped increments (saturating).
  - A push while full with a pop in the same cycle is accepted; level stays DEPTH; dropped unchanged.
  - start is ignored in CAPTURE.
- State HALTED:
  - No sampling; FIFO still drains.
  - start=1 -> CAPTURE: repeat counter and dropped cleared, first-sample flag set, FIFO contents kept.
- FIFO:
  - Circular read/write pointers of ADDR_W bits, wrapping at DEPTH.
  - out_valid = (level != 0).
  - out_pc/out_ans are driven from the head entry; they read 0 when empty.
  - Pop occurs when out_valid && out_ready.
  - Push then pop latency: a sample taken at edge N gives out_valid=1 after edge N. There is no same-cycle bypass.
  - Push and pop in the same cycle when not full and not empty: level unchanged.
  - Pop when empty: no effect.
- Outputs busy and halted are registered and follow the state.

Optional Feature:
- Macro: TRACE_MEM_DATA_EN.
- Defined:
  - Entries are 96 bits and include mem_data.
  - Extra port out_mem, output, 32 bits, head entry mem_data; reset/empty value 0.
- Undefined:
  - Entries are 64 bits.
  - out_mem does not exist; mem_data is unused.

Test Plan:
- rst low 2 cycles then high, start pulse; pc 0x0,0x4,0x8,0xC on consecutive cycles; out_ready=1 -> out_pc sequence 0x0,0x4,0x8,0xC with matching ans, each out_valid one cycle after its sample, level never exceeds 1, dropped=0.
- out_ready=0, DEPTH=16, 20 distinct PCs 0x0..0x4C -> level=16, dropped=4; then out_ready=1 -> out_pc drains 0x0..0x3C in order, level reaches 0.
- pc 0x1C then 0x20 held 4 cycles (HALT_CYCLES=4) -> 0x20 pushed exactly once, halted=1 and busy=0 after the 4th repeat; later pc 0x24 not pushed; a start pulse resumes capture and 0x24 is pushed.
- FIFO full (level=16), out_ready=1 and new distinct pc in the same cycle -> level stays 16, dropped unchanged, last pushed entry appears after 16 pops.
- level=5 during CAPTURE, rst pulsed low mid-cycle -> level=0, out_valid=0, busy=0, halted=0 immediately (asynchronous); PCs after release are ignored until start.
- With TRACE_MEM_DATA_EN: pc 0x40 sampled with mem_data 0xDEADBEEF -> out_mem=0xDEADBEEF alongside out_pc=0x40.
